// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store responder driving a 64-bit dword bus with strobes.
// Ports: lsu_* request/response, bus_* memory side. Option: LSU_MISALIGN_SPLIT_EN.
module lsu_mem_port #(
  parameter int XLEN = 64,
  parameter int ALEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_valid,
  input  logic            memrw,
  input  logic [1:0]      memword,
  input  logic            memsign,
  input  logic [ALEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_busy,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_misalign,
  output logic            bus_req,
  output logic            bus_we,
  output logic [ALEN-1:0] bus_addr,
  output logic [7:0]      bus_wstrb,
  output logic [63:0]     bus_wdata,
  input  logic            bus_ack,
  input  logic [63:0]     bus_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
`ifdef LSU_MISALIGN_SPLIT_EN
    BEAT1 = 2'd2,
`endif
    RESP  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_n;

  logic            we_q;
  logic [1:0]      size_q;
  logic            sign_q;
  logic [2:0]      off_q;
  logic            fault_q;
  logic [XLEN-1:0] rdata_q;
  logic [ALEN-1:0] bus_addr_q;
  logic [7:0]      bus_wstrb_q;
  logic [63:0]     bus_wdata_q;

  logic [7:0]      req_mask;
  logic            req_fault;
  logic            last_beat;
  logic [63:0]     ld_src;
  logic [63:0]     ld_ext;

  always_comb begin
    req_mask  = 8'h01;
    req_fault = 1'b0;
    unique case (memword)
      2'b00: req_mask = 8'h01;
      2'b01: begin
        req_mask  = 8'h03;
        req_fault = lsu_addr[0];
      end
      2'b10: begin
        req_mask  = 8'h0F;
        req_fault = |lsu_addr[1:0];
      end
      default: begin
        req_mask  = 8'hFF;
        req_fault = |lsu_addr[2:0];
      end
    endcase
`ifdef LSU_MISALIGN_SPLIT_EN
    req_fault = 1'b0;
`endif
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Low half feeds BEAT0, high half (bytes past the dword) feeds BEAT1.
  logic [15:0]  req_strb;
  logic [127:0] req_wd;
  logic         cross_q;
  logic [7:0]   strb_hi_q;
  logic [63:0]  wdata_hi_q;
  logic [63:0]  beat0_q;
  logic [127:0] ld_cat;

  assign req_strb = {8'h00, req_mask} << lsu_addr[2:0];
  assign req_wd   = {64'h0, lsu_wdata} << {lsu_addr[2:0], 3'b000};

  always_comb begin
    ld_cat = {64'h0, bus_rdata};
    if (state_q == BEAT1) ld_cat = {bus_rdata, beat0_q};
  end

  assign ld_src    = 64'(ld_cat >> {off_q, 3'b000});
  assign last_beat = !(state_q == BEAT0 && cross_q);
  assign bus_req   = (state_q == BEAT0) || (state_q == BEAT1);
`else
  logic [7:0]  req_strb;
  logic [63:0] req_wd;

  assign req_strb  = req_mask << lsu_addr[2:0];
  assign req_wd    = lsu_wdata << {lsu_addr[2:0], 3'b000};
  assign ld_src    = bus_rdata >> {off_q, 3'b000};
  assign last_beat = 1'b1;
  assign bus_req   = (state_q == BEAT0);
`endif

  // memsign = 1 selects zero-extension.
  always_comb begin
    ld_ext = ld_src;
    unique case (size_q)
      2'b00: ld_ext = sign_q ? {56'h0, ld_src[7:0]}
                             : {{56{ld_src[7]}}, ld_src[7:0]};
      2'b01: ld_ext = sign_q ? {48'h0, ld_src[15:0]}
                             : {{48{ld_src[15]}}, ld_src[15:0]};
      2'b10: ld_ext = sign_q ? {32'h0, ld_src[31:0]}
                             : {{32{ld_src[31]}}, ld_src[31:0]};
      default: ld_ext = ld_src;
    endcase
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (lsu_valid) state_n = req_fault ? RESP : BEAT0;
      end
      BEAT0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (bus_ack) state_n = cross_q ? BEAT1 : RESP;
`else
        if (bus_ack) state_n = RESP;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BEAT1: begin
        if (bus_ack) state_n = RESP;
      end
`endif
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      off_q       <= 3'd0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= 8'h00;
      bus_wdata_q <= 64'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q     <= 1'b0;
      strb_hi_q   <= 8'h00;
      wdata_hi_q  <= 64'h0;
      beat0_q     <= 64'h0;
`endif
    end else begin
      if (state_q == IDLE && lsu_valid) begin
        we_q        <= memrw;
        size_q      <= memword;
        sign_q      <= memsign;
        off_q       <= lsu_addr[2:0];
        fault_q     <= req_fault;
        rdata_q     <= '0;
        bus_addr_q  <= {lsu_addr[ALEN-1:3], 3'b000};
        bus_wstrb_q <= req_strb[7:0];
        bus_wdata_q <= memrw ? req_wd[63:0] : 64'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
        cross_q     <= |req_strb[15:8];
        strb_hi_q   <= req_strb[15:8];
        wdata_hi_q  <= memrw ? req_wd[127:64] : 64'h0;
`endif
      end
      if (bus_req && bus_ack && last_beat) begin
        rdata_q <= we_q ? '0 : ld_ext;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (bus_req && bus_ack && !last_beat) begin
        beat0_q     <= bus_rdata;
        bus_addr_q  <= bus_addr_q + ALEN'(8);
        bus_wstrb_q <= strb_hi_q;
        bus_wdata_q <= wdata_hi_q;
      end
`endif
    end
  end

  assign bus_we       = bus_req & we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wstrb    = bus_wstrb_q;
  assign bus_wdata    = bus_wdata_q;
  assign lsu_busy     = (state_q != IDLE);
  assign lsu_done     = (state_q == RESP);
  assign lsu_misalign = lsu_done & fault_q;
  assign lsu_rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: randomized bench for lsu_mem_port against a byte-level
// memory model; the bench acts as requester and bus responder.
module tb_lsu_mem_port;
  localparam int XLEN = 64;
  localparam int ALEN = 64;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            lsu_valid = 1'b0;
  logic            memrw = 1'b0;
  logic [1:0]      memword = 2'b00;
  logic            memsign = 1'b0;
  logic [ALEN-1:0] lsu_addr = '0;
  logic [XLEN-1:0] lsu_wdata = '0;
  logic            lsu_busy;
  logic            lsu_done;
  logic [XLEN-1:0] lsu_rdata;
  logic            lsu_misalign;
  logic            bus_req;
  logic            bus_we;
  logic [ALEN-1:0] bus_addr;
  logic [7:0]      bus_wstrb;
  logic [63:0]     bus_wdata;
  logic            bus_ack = 1'b0;
  logic [63:0]     bus_rdata = 64'h0;

  always #5 clk = ~clk;

  lsu_mem_port #(.XLEN(XLEN), .ALEN(ALEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .memrw(memrw),
    .memword(memword), .memsign(memsign),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done),
    .lsu_rdata(lsu_rdata), .lsu_misalign(lsu_misalign),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h",
               tag, got, exp);
    end
  endtask

  logic [7:0] mem [logic [63:0]];

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ (a[15:8] * 8'd29) ^ 8'h5a;
  endfunction

  function automatic logic [63:0] rd_dword(input logic [63:0] b);
    logic [63:0] v;
    v = 64'h0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = rd_byte(b + 64'(i));
    return v;
  endfunction

  task automatic set_dword(input logic [63:0] b,
                           input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem[b + 64'(i)] = v[8*i +: 8];
  endtask

  // A lane is strobed when its byte address lies inside the access.
  function automatic logic [7:0] exp_strb(input logic [63:0] base,
                                          input logic [63:0] a,
                                          input int n);
    logic [7:0] s;
    logic [63:0] ba;
    s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ba = base + 64'(i);
      s[i] = (ba >= a) && (ba < a + 64'(n));
    end
    return s;
  endfunction

  // Lane i carries store-data byte (lane address - access address).
  function automatic logic [63:0] exp_wdata(input logic [63:0] base,
                                            input logic [63:0] a,
                                            input logic [63:0] wd,
                                            input logic rw);
    logic [63:0] r;
    logic [63:0] ba;
    int k;
    r = 64'h0;
    if (!rw) return r;
    for (int i = 0; i < 8; i++) begin
      ba = base + 64'(i);
      if (ba >= a && ba - a < 64'd8) begin
        k = int'(ba - a);
        r[8*i +: 8] = wd[8*k +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] a,
                                           input int n,
                                           input logic zext);
    logic [63:0] v;
    v = 64'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 64'(i));
    if (!zext && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hff;
    return v;
  endfunction

  // Entered and left on a falling edge.
  task automatic do_txn(input logic rw, input logic [1:0] word,
                        input logic sign, input logic [63:0] a,
                        input logic [63:0] wd, input int d0,
                        input int d1, output logic [63:0] got);
    int n;
    int nb;
    int d;
    bit mis;
    logic [63:0] base;
    logic [63:0] bb;
    n    = 1 << word;
    mis  = !SPLIT && ((a % 64'(n)) != 64'd0);
    nb   = mis ? 0
         : ((SPLIT && (int'(a[2:0]) + n > 8)) ? 2 : 1);
    base = {a[63:3], 3'b000};
    lsu_valid = 1'b1;
    memrw     = rw;
    memword   = word;
    memsign   = sign;
    lsu_addr  = a;
    lsu_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      d  = (b == 0) ? d0 : d1;
      bb = base + 64'(8 * b);
      for (int w = 0; w <= d; w++) begin
        check("bus_req", bus_req, 1);
        check("busy", lsu_busy, 1);
        check("done_early", lsu_done, 0);
        check("bus_addr", bus_addr, bb);
        check("bus_we", bus_we, rw);
        check("bus_wstrb", bus_wstrb, exp_strb(bb, a, n));
        check("bus_wdata", bus_wdata, exp_wdata(bb, a, wd, rw));
        if (w == d) begin
          bus_ack   = 1'b1;
          bus_rdata = rd_dword(bb);
        end
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = {$urandom, $urandom};
      end
    end
    check("resp_req", bus_req, 0);
    check("done", lsu_done, 1);
    check("resp_busy", lsu_busy, 1);
    check("misalign", lsu_misalign, mis);
    check("rdata", lsu_rdata,
          (rw || mis) ? 64'h0 : exp_load(a, n, sign));
    got = lsu_rdata;
    if (rw && !mis)
      for (int i = 0; i < n; i++) mem[a + 64'(i)] = wd[8*i +: 8];
    lsu_valid = 1'b0;
    @(negedge clk);
    check("done_pulse", lsu_done, 0);
    check("idle_busy", lsu_busy, 0);
  endtask

  logic [63:0] got;
  logic [63:0] a;
  logic [63:0] wd;
  logic [1:0]  word;

  initial begin
    #7;
    check("rst_busy", lsu_busy, 0);
    check("rst_done", lsu_done, 0);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_mis", lsu_misalign, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_strb", bus_wstrb, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rdata", lsu_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_dword(64'h1000, 64'h8000_0001_0000_0000);
    do_txn(0, 2'b10, 0, 64'h1004, 64'h0, 0, 0, got);
    check("tp_lw", got, 64'hFFFF_FFFF_8000_0001);
    do_txn(1, 2'b00, 0, 64'h2003, 64'hAB, 2, 0, got);
    check("tp_sb_mem", {56'h0, rd_byte(64'h2003)}, 64'hAB);
    set_dword(64'h3000, 64'hFEDC_0000_0000_0000);
    do_txn(0, 2'b01, 1, 64'h3006, 64'h0, 1, 0, got);
    check("tp_lhu", got, 64'h0000_0000_0000_FEDC);
    do_txn(0, 2'b01, 0, 64'h3006, 64'h0, 0, 0, got);
    check("tp_lh", got, 64'hFFFF_FFFF_FFFF_FEDC);
    do_txn(0, 2'b10, 0, 64'h4002, 64'h0, 0, 0, got);
    set_dword(64'h5000, 64'h2211_0000_0000_0000);
    set_dword(64'h5008, 64'h0000_8877_6655_4433);
    do_txn(0, 2'b11, 0, 64'h5006, 64'h0, 1, 2, got);
    do_txn(0, 2'b11, 1, 64'h5000, 64'h0, 0, 0, got);

    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("idle_ack_busy", lsu_busy, 0);
    check("idle_ack_done", lsu_done, 0);

    lsu_valid = 1'b1;
    memrw     = 1'b0;
    memword   = 2'b11;
    lsu_addr  = 64'h6000;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_req", bus_req, 1);
    rst_n     = 1'b0;
    lsu_valid = 1'b0;
    #1;
    check("rst_mid_req", bus_req, 0);
    check("rst_mid_busy", lsu_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", lsu_done, 0);
    end
    do_txn(0, 2'b10, 1, 64'h1004, 64'h0, 0, 0, got);
    check("post_rst_lwu", got, 64'h0000_0000_8000_0001);

    for (int t = 0; t < 250; t++) begin
      word = 2'($urandom_range(0, 3));
      a    = 64'h8000 + 64'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1)
        a = a & ~(64'(1 << word) - 64'd1);
      wd = {$urandom, $urandom};
      do_txn(1'($urandom_range(0, 1)), word,
             1'($urandom_range(0, 1)), a, wd,
             $urandom_range(0, 3), $urandom_range(0, 3), got);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Responder side of the control unit's memory control outputs (memrw, memword, memsign).
- Takes one load/store request per transaction and drives a 64-bit word-addressed data bus with byte strobes.
- Returns the shifted and extended load result to the write-back stage, with a busy/stall indication.
- Sits between the execute stage (ALU address, rs2 data) and the data memory.

Parameters:
- XLEN, 64, register/data width.
- ALEN, 64, address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lsu_valid  in  1  request present; sampled only in IDLE.
- memrw  in  1  1 = write (MEM_WRITE), 0 = read (MEM_READ).
- memword  in  2  00 byte, 01 half, 10 word, 11 double.
- memsign  in  1  1 = zero-extend load, 0 = sign-extend.
- lsu_addr  in  ALEN  byte address from ALU.
- lsu_wdata  in  XLEN  store data, LSB-aligned.
- lsu_busy  out  1  request accepted and not yet completed (stall pipeline).
- lsu_done  out  1  one-cycle completion pulse.
- lsu_rdata  out  XLEN  extended load result; valid when lsu_done.
- lsu_misalign  out  1  misaligned-access fault; valid when lsu_done.
- bus_req  out  1  bus request.
- bus_we  out  1  write enable.
- bus_addr  out  ALEN  dword-aligned address, low 3 bits zero.
- bus_wstrb  out  8  byte strobes.
- bus_wdata  out  64  shifted write data.
- bus_ack  in  1  one-cycle acknowledge; bus_rdata valid in the same cycle for reads.
- bus_rdata  in  64  read data.

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE.
  - bus_req, bus_we, lsu_busy, lsu_done, lsu_misalign = 0.
  - bus_addr, bus_wstrb, bus_wdata, lsu_rdata = 0.
  - Reset mid-transaction abandons the access; no done pulse is produced.
- States: IDLE, BEAT0, BEAT1 (only with the optional feature), RESP.
- IDLE:
  - lsu_valid = 1 latches all request inputs.
  - Aligned request -> BEAT0 next cycle.
  - Misaligned request -> RESP with lsu_misalign = 1, no bus activity.
- Alignment rule: half requires addr[0] = 0; word requires addr[1:0] = 0; double requires addr[2:0] = 0; byte is always aligned.
- BEAT0:
  - bus_req = 1. bus_addr, bus_we, bus_wstrb, bus_wdata stay stable until bus_ack.
  - Let off = addr[2:0]. bus_wstrb = size mask (0x01/0x03/0x0F/0xFF) << off. bus_wdata = lsu_wdata << 8*off.
  - For reads, bus_wstrb carries the same mask, and bus_wdata = 0.
  - On bus_ack: capture bus_rdata, drop bus_req, go to RESP.
- RESP:
  - lsu_done = 1 for exactly one cycle, then IDLE.
  - Loads: lsu_rdata = (captured >> 8*off), truncated to size, then sign- or zero-extended per memsign.
  - Stores and faults: lsu_rdata = 0.
- lsu_busy = 1 in BEAT0, BEAT1 and RESP.
- Latency: aligned access with same-cycle ack = done 3 cycles after acceptance (accept, BEAT0, RESP).
- Back-to-back: a new request can be accepted the cycle after RESP.
- lsu_valid is ignored outside IDLE; the requester holds it until lsu_done.
- memword = 11 with memsign = 1 (LDU encoding) behaves as double, zero-extension is a no-op.
- bus_ack outside BEAT0/BEAT1 is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned accesses never fault.
  - An access that fits within one dword (off + size <= 8) completes in one beat using the shift rules above.
  - An access that crosses a dword boundary goes BEAT0 (bus_addr = A & ~7, strobes = low part) -> BEAT1 (bus_addr = (A & ~7) + 8, strobes = mask >> (8 - off), data = lsu_wdata >> 8*(8 - off)) -> RESP.
  - Loads take {beat1, beat0} >> 8*off, then truncate and extend.
  - lsu_misalign is always 0.
- Undefined: strict natural alignment as above; BEAT1 logic is absent.

Test Plan:
- Load word, addr 0x1004, memsign 0, bus_rdata 0x8000_0001_0000_0000 -> bus_addr 0x1000, wstrb 0xF0, lsu_rdata 0xFFFF_FFFF_8000_0001, done 3 cycles after accept.
- Store byte 0xAB at 0x2003 -> bus_we 1, wstrb 0x08, bus_wdata 0x0000_0000_AB00_0000; bus_req held across 2 wait cycles until bus_ack.
- Load half unsigned at 0x3006 with rdata 0xFEDC_0000_0000_0000 -> lsu_rdata 0x0000_0000_0000_FEDC; same access signed -> 0xFFFF_FFFF_FFFF_FEDC.
- Load word at 0x4002 (macro off) -> no bus_req, lsu_done with lsu_misalign 1, lsu_rdata 0.
- Load double at 0x5006 (macro on), beat0 rdata 0x2211_0000_0000_0000, beat1 rdata 0x0000_8877_6655_4433 -> two beats (0x5000, 0x5008), lsu_rdata 0x8877_6655_4433_2211.
- Assert rst_n low during BEAT0 -> bus_req drops immediately, no lsu_done; the next request after reset completes normally.
